dcache_ctrl: RTL

Direct-mapped, write-through, no-write-allocate data cache controller between the RISC core's load/store port and the multi-cycle main data memory. Hits return data in the same cycle. Misses and all writes stall the core while the controller runs the memory handshake. A read miss refills one 4-word line.

---
 rtl/dcache_ctrl_pkg.sv | 8 +
 rtl/dcache_array.sv | 38 +++
 rtl/dcache_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: default geometry and FSM encoding shared by the data cache controller files.
package dcache_ctrl_pkg;
   localparam int DC_DATA_W   = 32;
   localparam int DC_ADDR_W   = 10;
   localparam int DC_INDEX_W  = 5;
   localparam int DC_OFFSET_W = 2;
   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped tag/valid/data storage, synchronous write and asynchronous lookup.
module dcache_array
   import dcache_ctrl_pkg::*;
#(
   parameter int DATA_W   = DC_DATA_W,
   parameter int INDEX_W  = DC_INDEX_W,
   parameter int OFFSET_W = DC_OFFSET_W,
   parameter int TAG_W    = DC_ADDR_W - DC_INDEX_W - DC_OFFSET_W
) (
   input  logic                clk,
   input  logic                rst_i,
   input  logic [INDEX_W-1:0]  idx_i,
   input  logic [OFFSET_W-1:0] rd_off_i,
   input  logic [TAG_W-1:0]    tag_i,
   output logic                hit_o,
   output logic [DATA_W-1:0]   rdata_o,
   input  logic                we_i,
   input  logic [OFFSET_W-1:0] wr_off_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic                tag_we_i
);
   localparam int LINES = 2 ** INDEX_W;
   localparam int WORDS = 2 ** OFFSET_W;
   logic [DATA_W-1:0] data_q [LINES][WORDS];
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINES-1:0]  valid_q;
   always_ff @(posedge clk) begin
      if (we_i) data_q[idx_i][wr_off_i] <= wdata_i;
      if (tag_we_i) tag_q[idx_i] <= tag_i;
   end
   // A line only becomes valid when its last refill word lands, so an aborted fill stays invisible.
   always_ff @(posedge clk) begin
      if (rst_i) valid_q <= '0;
      else if (tag_we_i) valid_q[idx_i] <= 1'b1;
   end
   assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
   assign rdata_o = data_q[idx_i][rd_off_i];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through, no-write-allocate data cache controller.
// Hits answer combinationally; read misses refill a whole line, every store goes to memory.
module dcache_ctrl
   import dcache_ctrl_pkg::*;
#(
   parameter int DATA_W   = DC_DATA_W,
   parameter int ADDR_W   = DC_ADDR_W,
   parameter int INDEX_W  = DC_INDEX_W,
   parameter int OFFSET_W = DC_OFFSET_W
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   state_e                state_q;
   logic [OFFSET_W-1:0]   cnt_q;
   logic [TAG_W-1:0]      tag;
   logic [INDEX_W-1:0]    idx;
   logic [OFFSET_W-1:0]   off;
   logic                  hit;
   logic [DATA_W-1:0]     line_word;
   logic                  idle, fill, write;
   assign tag   = cpu_addr[ADDR_W-1 -: TAG_W];
   assign idx   = cpu_addr[OFFSET_W +: INDEX_W];
   assign off   = cpu_addr[OFFSET_W-1:0];
   assign idle  = state_q == IDLE;
   assign fill  = state_q == FILL;
   assign write = state_q == WRITE;
   dcache_array #(
      .DATA_W   (DATA_W),
      .INDEX_W  (INDEX_W),
      .OFFSET_W (OFFSET_W),
      .TAG_W    (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst_i    (RST),
      .idx_i    (idx),
      .rd_off_i (off),
      .tag_i    (tag),
      .hit_o    (hit),
      .rdata_o  (line_word),
      .we_i     (mem_ready && (fill || (write && hit))),
      .wr_off_i (fill ? cnt_q : off),
      .wdata_i  (fill ? mem_rdata : cpu_wdata),
      .tag_we_i (fill && mem_ready && (cnt_q == '1))
   );
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu_wr) state_q <= WRITE;
               else if (cpu_rd && !hit) begin
                  state_q <= FILL;
                  cnt_q   <= '0;
               end
            end
            FILL: begin
               if (mem_ready) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == '1) state_q <= IDLE;
               end
            end
            WRITE: if (mem_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   // Memory-side outputs decode straight from the registered state, so they drop with it on reset.
   assign cpu_stall = idle ? (cpu_wr || (cpu_rd && !hit)) : (fill || !mem_ready);
   assign cpu_rdata = (idle && cpu_rd && !cpu_wr && hit) ? line_word : '0;
   assign mem_rd    = fill;
   assign mem_wr    = write;
   assign mem_addr  = fill ? {cpu_addr[ADDR_W-1:OFFSET_W], cnt_q} : (write ? cpu_addr : '0);
   assign mem_wdata = write ? cpu_wdata : '0;
endmodule
